// File: rtl/vga_arb_pkg.sv
// Shared constants and types for the VGA pixel-write arbiter.
// Default geometry matches the 160x120 adaptor.
package vga_arb_pkg;

  localparam int NUM_REQ       = 3;
  localparam int X_W_DEF       = 8;
  localparam int Y_W_DEF       = 7;
  localparam int C_W_DEF       = 3;
  localparam int MAX_BURST_DEF = 19200;
  localparam int CNT_W         = 15;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_e;

  localparam logic [1:0] REQ_GRID  = 2'd0;
  localparam logic [1:0] REQ_NOTE  = 2'd1;
  localparam logic [1:0] REQ_SCORE = 2'd2;

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Round-robin picker: first asserted requester after last_owner,
// searched in order last_owner+1, +2, +3 (mod NUM_REQ).
module rr_pick
  import vga_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [1:0]         pick_idx
);

  int cand;

  // Walk the search order backwards so the earliest hit wins.
  always_comb begin
    pick     = '0;
    pick_idx = last_owner;
    cand     = 0;
    for (int o = NUM_REQ; o >= 1; o--) begin
      cand = (int'(last_owner) + o) % NUM_REQ;
      if (req[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
        pick_idx   = 2'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Burst-granting round-robin arbiter for the VGA adaptor write port.
// Define VGA_ARB_WATCHDOG_EN to force-release bursts at MAX_BURST pixels.
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int C_W       = C_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     last,
  input  logic [NUM_REQ*X_W-1:0] x_in,
  input  logic [NUM_REQ*Y_W-1:0] y_in,
  input  logic [NUM_REQ*C_W-1:0] colour_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   plot,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic [CNT_W-1:0]       pixel_count,
  output logic                   burst_timeout
);

  if (MAX_BURST < 1 || MAX_BURST > 32767) begin : g_bad_max_burst
    $error("MAX_BURST must fit the 15-bit pixel counter");
  end

  arb_state_e         state_q, state_d;
  logic [1:0]         last_owner_q, last_owner_d;
  logic [1:0]         own_q, own_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [C_W-1:0]     colour_q, colour_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;

  logic [NUM_REQ-1:0] pick;
  logic [1:0]         pick_idx;
  logic               wd_hit;

  rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick),
    .pick_idx   (pick_idx)
  );

`ifdef VGA_ARB_WATCHDOG_EN
  assign wd_hit = (cnt_q == CNT_W'(MAX_BURST - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    own_d        = own_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    plot_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    cnt_d        = cnt_q;
    tmo_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          own_d   = pick_idx;
          grant_d = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (req[own_q]) begin
          plot_d   = 1'b1;
          x_d      = x_in[int'(own_q)*X_W +: X_W];
          y_d      = y_in[int'(own_q)*Y_W +: Y_W];
          colour_d = colour_in[int'(own_q)*C_W +: C_W];
          cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (last[own_q] || wd_hit) begin
            state_d      = IDLE;
            grant_d      = '0;
            busy_d       = 1'b0;
            last_owner_d = own_q;
            tmo_d        = wd_hit && !last[own_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= REQ_SCORE;
      own_q        <= REQ_GRID;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      own_q        <= own_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = busy_q;
  assign plot          = plot_q;
  assign x             = x_q;
  assign y             = y_q;
  assign colour        = colour_q;
  assign pixel_count   = cnt_q;
  assign burst_timeout = tmo_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed bursts plus random traffic
// checked every cycle against an owner/queue-level reference model.
module tb_vga_write_arbiter;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int MB = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0]      req, last;
  logic [3*XW-1:0] x_in;
  logic [3*YW-1:0] y_in;
  logic [3*CW-1:0] colour_in;
  logic [2:0]      grant;
  logic            busy, plot, burst_timeout;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;
  logic [14:0]     pixel_count;

  vga_write_arbiter #(.MAX_BURST(MB), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .last(last),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .grant(grant), .busy(busy), .plot(plot), .x(x), .y(y),
    .colour(colour), .pixel_count(pixel_count),
    .burst_timeout(burst_timeout)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, whose turn is next, what was written.
  int m_own, m_lo, m_cnt, m_x, m_y, m_c;
  bit m_plot, m_tmo, chk_en = 1'b0;

  always @(posedge clock) begin
    bit rel, found;
    int c;
    m_plot = 1'b0;
    m_tmo  = 1'b0;
    if (reset) begin
      m_own = -1; m_lo = 2; m_cnt = 0;
      m_x = 0; m_y = 0; m_c = 0;
      chk_en = 1'b1;
    end else if (m_own < 0) begin
      found = 1'b0;
      for (int o = 1; o <= 3; o++) begin
        c = (m_lo + o) % 3;
        if (!found && req[c]) begin
          found = 1'b1; m_own = c; m_cnt = 0;
        end
      end
    end else if (req[m_own]) begin
      m_plot = 1'b1;
      m_x = int'(x_in[m_own*XW +: XW]);
      m_y = int'(y_in[m_own*YW +: YW]);
      m_c = int'(colour_in[m_own*CW +: CW]);
      if (m_cnt < 32767) m_cnt++;
      rel = last[m_own];
`ifdef VGA_ARB_WATCHDOG_EN
      if (!rel && m_cnt == MB) begin
        rel = 1'b1; m_tmo = 1'b1;
      end
`endif
      if (rel) begin
        m_lo = m_own; m_own = -1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("grant", 32'(grant), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
      check("busy", 32'(busy), 32'(m_own >= 0));
      check("plot", 32'(plot), 32'(m_plot));
      check("x", 32'(x), m_x);
      check("y", 32'(y), m_y);
      check("colour", 32'(colour), m_c);
      check("pixel_count", 32'(pixel_count), m_cnt);
      check("burst_timeout", 32'(burst_timeout), 32'(m_tmo));
    end
  end

  // Requester-side stimulus state.
  int rem[3], sent[3], nb[3], blen[3], xb[3], yb[3], cb[3];
  logic [2:0] stall;
  bit rnd, rst_req;
  int n;
  logic [31:0] g_log[64], p_log[64], x_log[64], c_log[64], t_log[64];

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic log_now();
    if (n < 64) begin
      g_log[n] = 32'(grant); p_log[n] = 32'(plot); x_log[n] = 32'(x);
      c_log[n] = 32'(pixel_count); t_log[n] = 32'(burst_timeout);
    end
  endtask

  task automatic cyc();
    logic [2:0] acc;
    reset = rst_req;
    for (int i = 0; i < 3; i++) begin
      if (rnd && rem[i] == 0 && $urandom_range(0, 5) == 0)
        rem[i] = $urandom_range(1, 10);
      req[i] = (rem[i] > 0) && !stall[i];
      if (req[i]) last[i] = (rem[i] == 1);
      else last[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        x_in[i*XW +: XW] = XW'($urandom);
        y_in[i*YW +: YW] = YW'($urandom);
        colour_in[i*CW +: CW] = CW'($urandom);
      end else begin
        x_in[i*XW +: XW] = XW'(xb[i] + sent[i]);
        y_in[i*YW +: YW] = YW'(yb[i]);
        colour_in[i*CW +: CW] = CW'(cb[i]);
      end
    end
    acc = req & grant & {3{~reset}};
    next();
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        sent[i]++;
        rem[i]--;
        if (rem[i] == 0 && nb[i] > 0) begin
          rem[i] = blen[i];
          nb[i]--;
        end
      end
    end
    n++;
    log_now();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; sent[i] = 0; nb[i] = 0; blen[i] = 0;
      xb[i] = 0; yb[i] = 0; cb[i] = 0;
    end
    stall = '0;
    rst_req = 1'b1;
    cyc();
    rst_req = 1'b0;
    n = 0;
    log_now();
  endtask

  initial begin
    int tp;
    reset = 1'b1; req = '0; last = '0;
    x_in = '0; y_in = '0; colour_in = '0;
    rnd = 1'b0; rst_req = 1'b0; stall = '0; n = 0;
    repeat (2) next();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_count", 32'(pixel_count), 32'd0);
    check("rst_x", 32'(x), 32'd0);

    // Single 4-pixel burst from requester 0.
    do_reset();
    rem[0] = 4; xb[0] = 10; yb[0] = 5; cb[0] = 4;
    repeat (6) cyc();
    check("t1_grant_c0", g_log[0], 32'd0);
    check("t1_grant_c1", g_log[1], 32'd1);
    check("t1_plot_c1", p_log[1], 32'd0);
    for (int k = 2; k <= 5; k++) begin
      check("t1_plot", p_log[k], 32'd1);
      check("t1_x", x_log[k], 32'(8 + k));
    end
    check("t1_grant_c4", g_log[4], 32'd1);
    check("t1_grant_c5", g_log[5], 32'd0);
    check("t1_count_c5", c_log[5], 32'd4);

    // All three requesting, 2-pixel bursts: order 0,1,2,0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rem[i] = 2; blen[i] = 2; xb[i] = 30 + 10 * i;
    end
    nb[0] = 1;
    repeat (13) cyc();
    check("t2_g1", g_log[1], 32'd1);
    check("t2_g3", g_log[3], 32'd0);
    check("t2_g4", g_log[4], 32'd2);
    check("t2_g6", g_log[6], 32'd0);
    check("t2_g7", g_log[7], 32'd4);
    check("t2_g9", g_log[9], 32'd0);
    check("t2_g10", g_log[10], 32'd1);
    check("t2_g12", g_log[12], 32'd0);

    // Owner stall for 3 cycles mid-burst.
    do_reset();
    rem[1] = 6; xb[1] = 20;
    for (int k = 0; k < 11; k++) begin
      stall[1] = (k >= 4 && k <= 6);
      cyc();
    end
    for (int k = 5; k <= 7; k++) check("t3_stall_plot", p_log[k], 32'd0);
    check("t3_grant_held", g_log[6], 32'd2);
    check("t3_count_frozen", c_log[7], 32'd3);
    check("t3_x_held", x_log[6], 32'd22);
    check("t3_x_resume", x_log[8], 32'd23);
    check("t3_count_end", c_log[10], 32'd6);
    check("t3_release", g_log[10], 32'd0);

    // Reset mid-burst, then requester 0 wins over requester 2.
    do_reset();
    rem[0] = 20; xb[0] = 50;
    for (int k = 0; k < 12; k++) begin
      rst_req = (k == 6);
      if (k == 7) begin
        rem[0] = 2; sent[0] = 0; rem[2] = 2; xb[2] = 90;
      end
      cyc();
    end
    rst_req = 1'b0;
    check("t4_count_c6", c_log[6], 32'd5);
    check("t4_plot_c6", p_log[6], 32'd1);
    check("t4_grant_rst", g_log[7], 32'd0);
    check("t4_plot_rst", p_log[7], 32'd0);
    check("t4_count_rst", c_log[7], 32'd0);
    check("t4_first_r0", g_log[8], 32'd1);
    check("t4_then_r2", g_log[11], 32'd4);

    // Requester 2 never asserts last; requester 0 joins late.
    do_reset();
    rem[2] = 1000; xb[2] = 100;
    for (int k = 0; k < 17; k++) begin
      if (k == 3) rem[0] = 2;
      cyc();
    end
    tp = 0;
    for (int k = 0; k <= 17; k++) tp += int'(t_log[k]);
`ifdef VGA_ARB_WATCHDOG_EN
    check("t5_grant_c8", g_log[8], 32'd4);
    check("t5_grant_drop", g_log[9], 32'd0);
    check("t5_tmo_c9", t_log[9], 32'd1);
    check("t5_last_plot", p_log[9], 32'd1);
    check("t5_last_x", x_log[9], 32'd107);
    check("t5_count", c_log[9], 32'd8);
    check("t5_r0_grant", g_log[10], 32'd1);
    check("t5_tmo_pulses", 32'(tp), 32'd1);
`else
    check("t5_grant_c9", g_log[9], 32'd4);
    check("t5_grant_c16", g_log[16], 32'd4);
    check("t5_count", c_log[15], 32'd14);
    check("t5_tmo_pulses", 32'(tp), 32'd0);
`endif

    // Random traffic with stalls, stray last bits and occasional resets.
    do_reset();
    rnd = 1'b1;
    repeat (2500) begin
      rst_req = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 3; i++) stall[i] = ($urandom_range(0, 4) == 0);
      cyc();
    end
    rst_req = 1'b0;
    rnd = 1'b0;
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
